tp_tile_sequencer: RTL and testbench

Autonomous tile sequencer for the transpose accelerator's R-type custom-instruction port (opcode 0x33, funct7 0x02). On a single start command it:

- streams an R×C tile from a source memory into A SRAM with TP_AWR;
- issues TP_START and polls TP_STAT until done;
- reads the transposed C×R tile back with TP_BRD and writes it to a destination memory.

It sits between a DMA/CPU configuration register block and the transpose custom-instruction wrapper, replacing CPU-driven instruction loops.

---
 rtl/tp_seq_pkg.sv | 35 +++
 rtl/tp_seq_walker.sv | 38 +++
 rtl/tp_tile_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_tp_tile_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_seq_pkg.sv
// rtl/tp_seq_pkg.sv - shared constants, state type and instruction encoder for the tile sequencer
package tp_seq_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'h33;
  localparam logic [6:0] F7_TP     = 7'h02;

  localparam logic [2:0] F3_AWR   = 3'b000;
  localparam logic [2:0] F3_START = 3'b001;
  localparam logic [2:0] F3_STAT  = 3'b010;
  localparam logic [2:0] F3_BRD   = 3'b011;

  localparam logic [4:0] TAG_STAT = 5'd1;
  localparam logic [4:0] TAG_BRD  = 5'd2;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_RD  = 4'd1,
    ST_LD_WT  = 4'd2,
    ST_LD_ISS = 4'd3,
    ST_ST_ISS = 4'd4,
    ST_PL_ISS = 4'd5,
    ST_PL_WT  = 4'd6,
    ST_RB_ISS = 4'd7,
    ST_RB_WT  = 4'd8,
    ST_WR     = 4'd9,
    ST_DONE   = 4'd10,
    ST_ERR    = 4'd11
  } tp_seq_state_e;

  // R-type word with rs1/rs2 register fields unused (operands travel on rs1_val/rs2_val)
  function automatic logic [31:0] tp_encode(input logic [2:0] f3, input logic [4:0] rd);
    return {F7_TP, 5'd0, 5'd0, f3, rd, OPC_RTYPE};
  endfunction

endpackage

// File: rtl/tp_seq_walker.sv
// rtl/tp_seq_walker.sv - 2-D outer/inner index counter with last-element flag
module tp_seq_walker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_step,
  input  logic [15:0] i_outer_lim,
  input  logic [15:0] i_inner_lim,
  output logic [15:0] o_outer,
  output logic [15:0] o_inner,
  output logic        o_last
);

  logic [15:0] r_outer;
  logic [15:0] r_inner;
  logic        w_inner_wrap;

  assign w_inner_wrap = (r_inner == i_inner_lim - 16'd1);
  assign o_last       = w_inner_wrap && (r_outer == i_outer_lim - 16'd1);
  assign o_outer      = r_outer;
  assign o_inner      = r_inner;

  // inner index runs fastest; on wrap the outer index advances
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_outer <= 16'd0;
      r_inner <= 16'd0;
    end else if (i_step) begin
      if (w_inner_wrap) begin
        r_inner <= 16'd0;
        r_outer <= r_outer + 16'd1;
      end else begin
        r_inner <= r_inner + 16'd1;
      end
    end
  end

endmodule

// File: rtl/tp_tile_sequencer.sv
// rtl/tp_tile_sequencer.sv - load, transpose and write back one tile via the TP custom-instruction port
module tp_tile_sequencer
  import tp_seq_pkg::*;
#(
  parameter int M        = 8,
  parameter int N        = 8,
  parameter int DATA_W   = 32,
  parameter int MADDR_W  = 32,
  parameter int POLL_MAX = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [MADDR_W-1:0] cfg_src_base,
  input  logic [MADDR_W-1:0] cfg_dst_base,
  input  logic [15:0]        cfg_rows,
  input  logic [15:0]        cfg_cols,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_err,
  output logic               src_re,
  output logic [MADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]  src_rdata,
  input  logic               src_rvalid,
  output logic               dst_we,
  output logic [MADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0]  dst_wdata,
  input  logic               dst_ready,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        rs1_val,
  output logic [31:0]        rs2_val,
  output logic [4:0]         rd_addr,
  input  logic               rd_we,
  input  logic [4:0]         rd_waddr,
  input  logic [31:0]        rd_wdata
);

  tp_seq_state_e      r_state;
  logic [MADDR_W-1:0] r_src_base;
  logic [MADDR_W-1:0] r_dst_base;
  logic [15:0]        r_rows;
  logic [15:0]        r_cols;
  logic [DATA_W-1:0]  r_data;
  logic [15:0]        r_poll_cnt;

  logic [15:0] w_r, w_c, w_i, w_j;
  logic        w_ld_last, w_rb_last;
  logic        w_ld_step, w_rb_step, w_clear;
  logic        w_hs;
  logic        w_dims_bad;
  logic        w_stat_hit, w_brd_hit;
  logic [15:0] w_poll_next;
  logic [31:0] w_src_off, w_dst_off;

  assign w_hs        = instr_valid && instr_ready;
  assign w_dims_bad  = (cfg_rows == 16'd0) || (cfg_cols == 16'd0) ||
                       (cfg_rows > 16'(M)) || (cfg_cols > 16'(N));
  assign w_stat_hit  = rd_we && (rd_waddr == TAG_STAT);
  assign w_brd_hit   = rd_we && (rd_waddr == TAG_BRD);
  assign w_poll_next = r_poll_cnt + 16'd1;

  // both walkers sit at (0,0) whenever the sequencer is idle
  assign w_clear   = (r_state == ST_IDLE);
  assign w_ld_step = (r_state == ST_LD_ISS) && w_hs && !w_ld_last;
  assign w_rb_step = (r_state == ST_WR) && dst_ready && !w_rb_last;

  // row-major offsets; 16x16 products fit 32 bits, final add wraps at MADDR_W
  assign w_src_off = {16'd0, w_r} * {16'd0, r_cols} + {16'd0, w_c};
  assign w_dst_off = {16'd0, w_i} * {16'd0, r_rows} + {16'd0, w_j};

  tp_seq_walker u_ld_walker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_step      (w_ld_step),
    .i_outer_lim (r_rows),
    .i_inner_lim (r_cols),
    .o_outer     (w_r),
    .o_inner     (w_c),
    .o_last      (w_ld_last)
  );

  tp_seq_walker u_rb_walker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_step      (w_rb_step),
    .i_outer_lim (r_cols),
    .i_inner_lim (r_rows),
    .o_outer     (w_i),
    .o_inner     (w_j),
    .o_last      (w_rb_last)
  );

  // sequencing FSM: load, start, poll, readback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_rows     <= 16'd0;
      r_cols     <= 16'd0;
      r_data     <= '0;
      r_poll_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_src_base <= cfg_src_base;
            r_dst_base <= cfg_dst_base;
            r_rows     <= cfg_rows;
            r_cols     <= cfg_cols;
            r_poll_cnt <= 16'd0;
            r_state    <= w_dims_bad ? ST_ERR : ST_LD_RD;
          end
        end
        ST_LD_RD: r_state <= ST_LD_WT;
        ST_LD_WT: begin
          if (src_rvalid) begin
            r_data  <= src_rdata;
            r_state <= ST_LD_ISS;
          end
        end
        ST_LD_ISS: begin
          if (w_hs) r_state <= w_ld_last ? ST_ST_ISS : ST_LD_RD;
        end
        ST_ST_ISS: begin
          if (w_hs) begin
            r_poll_cnt <= 16'd0;
            r_state    <= ST_PL_ISS;
          end
        end
        ST_PL_ISS: begin
          if (w_hs) r_state <= ST_PL_WT;
        end
        ST_PL_WT: begin
          if (w_stat_hit) begin
            if (rd_wdata[0]) begin
              r_state <= ST_RB_ISS;
            end else if (w_poll_next == 16'(POLL_MAX)) begin
              r_state <= ST_ERR;
            end else begin
              r_poll_cnt <= w_poll_next;
              r_state    <= ST_PL_ISS;
            end
          end
        end
        ST_RB_ISS: begin
          if (w_hs) r_state <= ST_RB_WT;
        end
        ST_RB_WT: begin
          if (w_brd_hit) begin
            r_data  <= DATA_W'(rd_wdata);
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (dst_ready) r_state <= w_rb_last ? ST_DONE : ST_RB_ISS;
        end
        ST_DONE:  r_state <= ST_IDLE;
        ST_ERR:   r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // outputs decode from registered state only, so they hold steady across stalls
  always_comb begin
    instr_valid = 1'b0;
    instr       = 32'd0;
    rs1_val     = 32'd0;
    rs2_val     = 32'd0;
    rd_addr     = 5'd0;
    src_re      = 1'b0;
    src_addr    = '0;
    dst_we      = 1'b0;
    dst_addr    = '0;
    dst_wdata   = '0;
    case (r_state)
      ST_LD_RD: begin
        src_re   = 1'b1;
        src_addr = r_src_base + MADDR_W'(w_src_off);
      end
      ST_LD_ISS: begin
        instr_valid = 1'b1;
        instr       = tp_encode(F3_AWR, 5'd0);
        rs1_val     = {w_r, w_c};
        rs2_val     = 32'(r_data);
      end
      ST_ST_ISS: begin
        instr_valid = 1'b1;
        instr       = tp_encode(F3_START, 5'd0);
      end
      ST_PL_ISS: begin
        instr_valid = 1'b1;
        instr       = tp_encode(F3_STAT, TAG_STAT);
        rd_addr     = TAG_STAT;
      end
      ST_RB_ISS: begin
        instr_valid = 1'b1;
        instr       = tp_encode(F3_BRD, TAG_BRD);
        rs1_val     = {w_i, w_j};
        rd_addr     = TAG_BRD;
      end
      ST_WR: begin
        dst_we    = 1'b1;
        dst_addr  = r_dst_base + MADDR_W'(w_dst_off);
        dst_wdata = r_data;
      end
      default: ;
    endcase
  end

  assign seq_busy = !(r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign seq_done = (r_state == ST_DONE);
  assign seq_err  = (r_state == ST_ERR);

endmodule

// File: tb/tb_tp_tile_sequencer.sv
// tb/tb_tp_tile_sequencer.sv - self-checking bench for tp_tile_sequencer
module tb_tp_tile_sequencer;

  localparam int M = 8, N = 8, DATA_W = 32, MADDR_W = 32, POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_src_base = '0, cfg_dst_base = '0;
  logic [15:0] cfg_rows = '0, cfg_cols = '0;
  logic        seq_busy, seq_done, seq_err;
  logic        src_re, src_rvalid;
  logic [31:0] src_addr, src_rdata;
  logic        dst_we, dst_ready;
  logic [31:0] dst_addr, dst_wdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, rs1_val, rs2_val;
  logic [4:0]  rd_addr, rd_waddr;
  logic        rd_we;
  logic [31:0] rd_wdata;

  always #5 clk = ~clk;

  tp_tile_sequencer #(.M(M), .N(N), .DATA_W(DATA_W), .MADDR_W(MADDR_W), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .src_re(src_re), .src_addr(src_addr), .src_rdata(src_rdata), .src_rvalid(src_rvalid),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_ready(dst_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memories and accelerator model
  logic [31:0] src_mem [logic [31:0]];
  logic [31:0] dst_mem [logic [31:0]];
  logic [31:0] exp_dst [logic [31:0]];
  logic [31:0] acc_a [0:M-1][0:N-1];
  logic [31:0] cur_src;
  int          cur_cols;

  int n_awr, n_start, n_stat, n_brd, n_dst_wr, n_done, n_err, n_re, n_iv, n_we;
  int ready_mode = 0, ready_low_left = 0, dst_mode = 0, stat_done_at = 1;
  bit spur_en = 0;

  // source memory: rvalid 1..3 cycles after the read strobe
  initial begin : src_model
    logic [31:0] a;
    int lat;
    src_rvalid = 1'b0;
    src_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && src_re) begin
        a   = src_addr;
        lat = $urandom_range(1, 3);
        repeat (lat) @(negedge clk);
        src_rdata  = src_mem.exists(a) ? src_mem[a] : 32'hBAD0BAD0;
        src_rvalid = 1'b1;
        @(negedge clk);
        src_rvalid = 1'b0;
        src_rdata  = $urandom;
      end
    end
  end

  // accelerator: takes instructions, answers STAT/BRD with tagged writebacks
  logic        acc_pend, iv_hold;
  int          acc_cd, acc_polls;
  logic [4:0]  acc_tag, h_rd;
  logic [31:0] acc_data, h_instr, h_rs1, h_rs2, ad;
  logic [15:0] hr, hc;
  initial begin : acc_model
    instr_ready = 1'b0;
    rd_we = 1'b0; rd_waddr = '0; rd_wdata = '0;
    acc_pend = 1'b0; iv_hold = 1'b0; acc_polls = 0; acc_cd = 0;
    forever begin
      @(negedge clk);
      rd_we = 1'b0; rd_waddr = '0; rd_wdata = '0;
      if (!rst_n) begin
        acc_pend = 1'b0; iv_hold = 1'b0; instr_ready = 1'b0;
      end else begin
        if (acc_pend) begin
          if (acc_cd == 0) begin
            rd_we = 1'b1; rd_waddr = acc_tag; rd_wdata = acc_data; acc_pend = 1'b0;
          end else begin
            if (spur_en && acc_tag == 5'd1) begin
              rd_we = 1'b1; rd_waddr = 5'd7; rd_wdata = 32'hFFFF_FFFF;
            end
            acc_cd--;
          end
        end
        if (ready_low_left > 0) begin
          instr_ready = 1'b0;
          ready_low_left--;
        end else begin
          instr_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (iv_hold) begin
          chk("instr_valid_hold", instr_valid, 1);
          chk("instr_hold", instr, h_instr);
          chk("rs1_hold", rs1_val, h_rs1);
          chk("rs2_hold", rs2_val, h_rs2);
          chk("rd_addr_hold", rd_addr, h_rd);
        end
        if (instr_valid && instr_ready) begin
          chk("instr_fixed", {instr[31:15], instr[6:0]}, {7'h02, 10'd0, 7'h33});
          chk("rd_addr_field", rd_addr, instr[11:7]);
          hr = rs1_val[31:16];
          hc = rs1_val[15:0];
          case (instr[14:12])
            3'b000: begin
              n_awr++;
              chk("awr_rd", instr[11:7], 0);
              ad = cur_src + 32'(hr) * 32'(cur_cols) + 32'(hc);
              chk("awr_data", rs2_val, src_mem.exists(ad) ? src_mem[ad] : 32'hBAD0BAD0);
              if (hr < 16'(M) && hc < 16'(N)) acc_a[hr][hc] = rs2_val;
            end
            3'b001: begin
              n_start++;
              acc_polls = 0;
              chk("start_ops", {rs1_val, rs2_val, 3'd0, instr[11:7]}, 0);
            end
            3'b010: begin
              n_stat++;
              acc_polls++;
              chk("stat_rd", instr[11:7], 1);
              acc_pend = 1'b1; acc_tag = 5'd1;
              acc_data = (stat_done_at != 0 && acc_polls >= stat_done_at) ? 32'h1 : 32'h6;
              acc_cd   = spur_en ? 2 : $urandom_range(0, 2);
            end
            3'b011: begin
              n_brd++;
              chk("brd_rd", instr[11:7], 2);
              chk("brd_rs2", rs2_val, 0);
              acc_pend = 1'b1; acc_tag = 5'd2;
              acc_data = (hr < 16'(N) && hc < 16'(M)) ? acc_a[hc][hr] : 32'hBAD1BAD1;
              acc_cd   = $urandom_range(0, 2);
            end
            default: chk("funct3_known", instr[14:12], 0);
          endcase
        end
        iv_hold = instr_valid && !instr_ready;
        h_instr = instr; h_rs1 = rs1_val; h_rs2 = rs2_val; h_rd = rd_addr;
      end
    end
  end

  // destination memory with configurable backpressure
  logic        dh, tog;
  logic [31:0] dh_addr, dh_data;
  initial begin : dst_model
    dst_ready = 1'b0; dh = 1'b0; tog = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dh = 1'b0; dst_ready = 1'b0;
      end else begin
        case (dst_mode)
          0: dst_ready = 1'b1;
          1: begin tog = ~tog; dst_ready = tog; end
          default: dst_ready = 1'($urandom_range(0, 1));
        endcase
        if (dh) begin
          chk("dst_we_hold", dst_we, 1);
          chk("dst_addr_hold", dst_addr, dh_addr);
          chk("dst_data_hold", dst_wdata, dh_data);
        end
        if (dst_we && dst_ready) begin
          dst_mem[dst_addr] = dst_wdata;
          n_dst_wr++;
        end
        dh = dst_we && !dst_ready;
        dh_addr = dst_addr; dh_data = dst_wdata;
      end
    end
  end

  // activity / completion monitor
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (seq_done) begin n_done++; chk("busy_low_at_done", seq_busy, 0); end
        if (seq_err) n_err++;
        if (src_re) n_re++;
        if (instr_valid) n_iv++;
        if (dst_we) n_we++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_awr = 0; n_start = 0; n_stat = 0; n_brd = 0; n_dst_wr = 0;
    n_done = 0; n_err = 0; n_re = 0; n_iv = 0; n_we = 0;
  endtask

  // mode: 0 random data, 1 sequential 1..R*C, 2 constant 0xDEADBEEF
  task automatic load_tile(input int rows, input int cols, input logic [31:0] sb,
                           input logic [31:0] db, input int mode);
    logic [31:0] a;
    src_mem.delete(); dst_mem.delete(); exp_dst.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        a = sb + 32'(r * cols + c);
        src_mem[a] = (mode == 1) ? 32'(r * cols + c + 1) : (mode == 2) ? 32'hDEADBEEF : $urandom;
      end
    for (int i = 0; i < cols; i++)
      for (int j = 0; j < rows; j++)
        exp_dst[db + 32'(i * rows + j)] = src_mem[sb + 32'(j * cols + i)];
    cur_src = sb; cur_cols = cols;
    clr_counts();
  endtask

  task automatic start_tile(input int rows, input int cols, input logic [31:0] sb, input logic [31:0] db);
    cfg_rows = 16'(rows); cfg_cols = 16'(cols);
    cfg_src_base = sb; cfg_dst_base = db;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 5000 && n_done == 0 && n_err == 0; k++) step();
    chk({tag, "_finished"}, (n_done + n_err) > 0, 1);
    step();
  endtask

  task automatic check_tile(input string tag, input int rows, input int cols, input int stats);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_err"}, n_err, 0);
    chk({tag, "_awr"}, n_awr, rows * cols);
    chk({tag, "_start"}, n_start, 1);
    chk({tag, "_stat"}, n_stat, stats);
    chk({tag, "_brd"}, n_brd, rows * cols);
    chk({tag, "_writes"}, n_dst_wr, rows * cols);
    foreach (exp_dst[a]) begin
      if (dst_mem.exists(a)) chk({tag, "_dst"}, dst_mem[a], exp_dst[a]);
      else chk({tag, "_dst_missing"}, a, 32'hFFFF_FFFF);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {seq_busy, seq_done, seq_err, src_re, dst_we, instr_valid}, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_rs1"}, rs1_val, 0);
    chk({tag, "_rs2"}, rs2_val, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_dst_addr"}, dst_addr, 0);
    chk({tag, "_dst_wdata"}, dst_wdata, 0);
  endtask

  initial begin : main
    int rr, cc, k;
    clr_counts();
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // 2x3 sequential tile, always ready, done on third poll
    load_tile(2, 3, 32'h100, 32'h200, 1);
    ready_mode = 0; dst_mode = 0; stat_done_at = 3;
    start_tile(2, 3, 32'h100, 32'h200);
    chk("t1_busy", seq_busy, 1);
    wait_end("t1");
    check_tile("t1", 2, 3, 3);
    chk("t1_b01", dst_mem.exists(32'h201) ? dst_mem[32'h201] : 32'h0, 32'd4);
    chk("t1_b21", dst_mem.exists(32'h205) ? dst_mem[32'h205] : 32'h0, 32'd6);

    // bad dimensions: zero rows, then too many cols
    for (int t = 0; t < 2; t++) begin
      clr_counts();
      start_tile(t == 0 ? 0 : 2, t == 0 ? 3 : N + 1, 32'h0, 32'h400);
      chk("bad_err_pulse", seq_err, 1);
      chk("bad_busy", seq_busy, 0);
      step();
      chk("bad_err_1cyc", seq_err, 0);
      repeat (5) step();
      chk("bad_err_count", n_err, 1);
      chk("bad_no_activity", {n_re[7:0], n_iv[7:0], n_we[7:0]}, 0);
    end

    // poll timeout
    load_tile(3, 2, 32'h40, 32'h80, 0);
    ready_mode = 1; stat_done_at = 0;
    start_tile(3, 2, 32'h40, 32'h80);
    wait_end("t3");
    chk("t3_err", n_err, 1);
    chk("t3_done", n_done, 0);
    chk("t3_stat", n_stat, POLL_MAX);
    chk("t3_brd", n_brd, 0);
    chk("t3_writes", n_dst_wr, 0);

    // 8x8 with a 5-cycle instr_ready stall mid-load and toggling dst_ready
    load_tile(8, 8, 32'h1000, 32'h2000, 0);
    ready_mode = 0; dst_mode = 1; stat_done_at = 2;
    start_tile(8, 8, 32'h1000, 32'h2000);
    for (k = 0; k < 2000 && n_awr < 10; k++) step();
    chk("t4_reach_mid_load", n_awr >= 10, 1);
    ready_low_left = 5;
    wait_end("t4");
    check_tile("t4", 8, 8, 2);

    // spurious tag-7 writeback, restart attempt while busy, addresses wrapping
    load_tile(3, 5, 32'hFFFF_FFF8, 32'hFFFF_FFFA, 0);
    ready_mode = 1; dst_mode = 2; stat_done_at = 2; spur_en = 1;
    start_tile(3, 5, 32'hFFFF_FFF8, 32'hFFFF_FFFA);
    repeat (4) step();
    start_tile(1, 1, 32'h0, 32'h0);
    wait_end("t5");
    spur_en = 0;
    check_tile("t5", 3, 5, 2);

    // randomized tiles
    for (int t = 0; t < 3; t++) begin
      rr = $urandom_range(1, M);
      cc = $urandom_range(1, N);
      stat_done_at = $urandom_range(1, 3);
      ready_mode = $urandom_range(0, 1);
      dst_mode = $urandom_range(0, 2);
      load_tile(rr, cc, 32'($urandom_range(0, 255)), 32'h3000, 0);
      start_tile(rr, cc, cur_src, 32'h3000);
      wait_end("rnd");
      check_tile("rnd", rr, cc, stat_done_at);
    end

    // reset during readback, then a 1x1 tile
    load_tile(4, 4, 32'h500, 32'h600, 0);
    ready_mode = 0; dst_mode = 0; stat_done_at = 1;
    start_tile(4, 4, 32'h500, 32'h600);
    for (k = 0; k < 2000 && n_brd < 3; k++) step();
    chk("t6_reach_readback", n_brd >= 3, 1);
    rst_n = 1'b0;
    step();
    chk_zero("t6_rst");
    chk("t6_no_done_err", n_done + n_err, 0);
    rst_n = 1'b1;
    step();
    load_tile(1, 1, 32'h700, 32'h800, 2);
    start_tile(1, 1, 32'h700, 32'h800);
    wait_end("t6b");
    check_tile("t6b", 1, 1, 1);
    chk("t6b_beef", dst_mem.exists(32'h800) ? dst_mem[32'h800] : 32'h0, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
